mav_sample_src: RTL and testbench
=================================

Name: mav_sample_src

Overview:
- Producer side of the MAV sample interface: drives the `d`/`en` pair that the moving-average block consumes.
- Samples are loaded into an internal FIFO through a simple write port.
- After a `start` pulse, one sample is emitted every GAP cycles as a single-cycle `en` strobe with `d` valid.
- Sits between the board/test loader and MAV; replaces hand-toggled `en`/`d` stimulus.

Parameters:
- DW, 16, sample width; matches MAV `d`.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- GAP, 4, cycles between successive `en` strobes; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe; pushes `wr_data` this cycle.
- wr_data  in  DW  sample to push.
- start  in  1  single-cycle pulse; begins emission.
- d  out  DW  sample to MAV; registered.
- en  out  1  single-cycle strobe; `d` valid when high; registered.
- busy  out  1  high while in RUN.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-low, one clock domain.
- Reset values: d=0, en=0, busy=0, count=0, empty=1, full=0. Pointers = 0; state = IDLE; gap counter = 0.
- FIFO storage:
  - Circular buffer with rd_ptr/wr_ptr of log2(DEPTH) bits; both wrap DEPTH-1 -> 0.
  - `count` tracks occupancy.
  - full = (count==DEPTH); empty = (count==0); both derived from the registered count.
- Write rule:
  - A push occurs when wr_en=1 and (!full or a pop occurs in the same cycle).
  - Otherwise the write is dropped silently; no state change.
- Same-cycle push and pop: count unchanged, both pointers advance.
  - Holds when full: the incoming sample is accepted.
  - Pop when empty never happens, so write-while-empty is a plain push.
- State IDLE:
  - en=0, busy=0.
  - start=1 -> RUN; gap counter loads GAP-1.
- State RUN:
  - busy=1.
  - Each cycle with gap counter != 0: decrement, en=0.
  - Gap counter == 0 and !empty: pop. Next cycle d=FIFO[rd_ptr] and en=1 for exactly one cycle; gap counter reloads GAP-1; stay in RUN.
  - Gap counter == 0 and empty: -> IDLE, en=0; d keeps its last value.
- start while in RUN is ignored.
- Latency: first `en` rises on the GAP-th rising edge after the edge that samples start; successive strobes are GAP cycles apart.
  - GAP=1 gives `en` on consecutive cycles.
- `d` holds its last emitted value between strobes; it changes only together with en=1.
- Writes during RUN are legal. A sample written before the due pop is emitted in order, with no gap skipped.
- rstn asserted mid-RUN: immediate return to the reset values above; FIFO contents are lost (pointers cleared).
- Order is strictly FIFO; no duplicates, no reordering.

Optional Feature:
- Macro: MAV_SAMPLE_SRC_DROP_CNT_EN.
- Defined:
  - Extra output port `drop_cnt`, out, 8 bits.
  - Increments by 1 on every dropped write (wr_en=1 while full with no same-cycle pop).
  - Saturates at 255; reset to 0; never cleared otherwise.
- Undefined: the port and counter are absent; dropped writes are invisible.

Test Plan:
- Load and emit: reset, push 0x0004,0x0002,0x0003,0x0001, pulse start (GAP=4).
  - Required: en high exactly 4 cycles, at start+4, +8, +12, +16.
  - d = 4,2,3,1 at those strobes.
  - busy falls at start+20; empty=1.
- Full boundary (DEPTH=8): push 0x0001..0x0009 with the block idle.
  - Required: full=1 after 8th push, count=8, 9th dropped.
  - Emission yields 1..8 only.
  - With macro defined, drop_cnt=1.
- Push+pop when full: FIFO full, wr_en=1 with 0x00AA on the cycle a pop occurs.
  - Required: count stays 8, write accepted.
  - 0x00AA emitted last.
- Empty start: start with count=0.
  - Required: busy high GAP cycles, then IDLE; en never asserted; d stays 0.
- Reset mid-operation: rstn low for one cycle between the 2nd and 3rd strobes.
  - Required: en, d, count = 0 immediately; empty=1.
  - No further strobes until new pushes and start.
- Refill during RUN: GAP=1, start with 1 entry, push 0x0005 on each of the next cycles.
  - Required: continuous en strobes; samples emitted in push order; no strobe skipped while count>0.

Source files
------------

// File: rtl/mav_sample_src.sv
// MAV sample source: a FIFO loaded through a write port, drained as one en/d strobe every GAP cycles after start.
// Optional drop counter output enabled by defining MAV_SAMPLE_SRC_DROP_CNT_EN.
module mav_sample_src #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int GAP   = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     start,
  output logic [DW-1:0]            d,
  output logic                     en,
  output logic                     busy,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [DW-1:0]   mem [DEPTH];
  logic            pop, push;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign busy  = (state_q == RUN);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign push  = wr_en && (!full || pop);

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          gap_d   = GAP_RELOAD;
        end
      end
      RUN: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (!empty) begin
          pop   = 1'b1;
          gap_d = GAP_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gap_q   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      d       <= '0;
      en      <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      en      <= pop;
      if (pop) begin
        d      <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the cleared pointers and count make old contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      drop_cnt <= '0;
    else if (wr_en && !push && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_mav_sample_src.sv
// Self-checking bench for mav_sample_src: GAP=4 instance for most sequences, GAP=1 instance for refill.
module tb_mav_sample_src;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en0, start0, wr_en1, start1;
  logic [15:0] wr_data0, wr_data1;
  logic [15:0] d0, d1;
  logic        en0, busy0, full0, empty0, en1, busy1, full1, empty1;
  logic [3:0]  count0, count1;
`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
  logic [7:0]  drop0, drop1;
`endif

  int checks = 0;
  int errors = 0;
  int strobes0 = 0;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  always #5 clk = ~clk;

  mav_sample_src #(.DW(16), .DEPTH(8), .GAP(4)) u0 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en0), .wr_data(wr_data0), .start(start0),
    .d(d0), .en(en0), .busy(busy0), .full(full0), .empty(empty0), .count(count0)
`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
    , .drop_cnt(drop0)
`endif
  );

  mav_sample_src #(.DW(16), .DEPTH(8), .GAP(1)) u1 (
    .clk(clk), .rstn(rstn), .wr_en(wr_en1), .wr_data(wr_data1), .start(start1),
    .d(d1), .en(en1), .busy(busy1), .full(full1), .empty(empty1), .count(count1)
`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
    , .drop_cnt(drop1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [15:0] v, input bit accept);
    wr_en0 = 1'b1;
    wr_data0 = v;
    tick();
    wr_en0 = 1'b0;
    if (accept) sb0.push_back(v);
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic wait_idle0(input string name);
    int n;
    n = 0;
    while (busy0 && n < 200) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, busy0, 1'b0);
  endtask

  // Scoreboards: every strobe must match the oldest accepted sample.
  always @(negedge clk) begin
    if (en0) begin
      strobes0++;
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected: got strobe d=%0h expected no strobe", d0);
      end else begin
        logic [15:0] e;
        e = sb0.pop_front();
        if (d0 !== e) begin
          errors++;
          $display("FAIL sb0_data: got %0h expected %0h", d0, e);
        end
      end
    end
    if (en1) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected: got strobe d=%0h expected no strobe", d1);
      end else begin
        logic [15:0] e;
        e = sb1.pop_front();
        if (d1 !== e) begin
          errors++;
          $display("FAIL sb1_data: got %0h expected %0h", d1, e);
        end
      end
    end
  end

  typedef struct {
    int          k;
    logic        en;
    logic [15:0] d;
    logic        busy;
    logic        empty;
  } vec_t;

  initial begin
    vec_t tbl[9];
    int   vi;
    int   s_before;

    tbl[0] = '{3,  1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{4,  1'b1, 16'h0004, 1'b1, 1'b0};
    tbl[2] = '{5,  1'b0, 16'h0004, 1'b1, 1'b0};
    tbl[3] = '{8,  1'b1, 16'h0002, 1'b1, 1'b0};
    tbl[4] = '{12, 1'b1, 16'h0003, 1'b1, 1'b0};
    tbl[5] = '{16, 1'b1, 16'h0001, 1'b1, 1'b1};
    tbl[6] = '{17, 1'b0, 16'h0001, 1'b1, 1'b1};
    tbl[7] = '{19, 1'b0, 16'h0001, 1'b1, 1'b1};
    tbl[8] = '{20, 1'b0, 16'h0001, 1'b0, 1'b1};

    rstn = 1'b0;
    wr_en0 = 0; start0 = 0; wr_data0 = '0;
    wr_en1 = 0; start1 = 0; wr_data1 = '0;
    repeat (2) tick();
    chk("rst_d", d0, 0);
    chk("rst_en", en0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);
    rstn = 1'b1;
    tick();

    // Empty start: busy for GAP cycles, no strobe, d untouched.
    pulse_start0();
    chk("es_busy0", busy0, 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("es_busy%0d", k), busy0, (k < 4) ? 1 : 0);
      chk($sformatf("es_en%0d", k), en0, 0);
      chk($sformatf("es_d%0d", k), d0, 0);
    end

    // Load and emit, checked against the cycle table.
    push0(16'h0004, 1); push0(16'h0002, 1); push0(16'h0003, 1); push0(16'h0001, 1);
    chk("le_count", count0, 4);
    pulse_start0();
    vi = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (vi < 9 && tbl[vi].k == k) begin
        chk($sformatf("le_en_k%0d", k), en0, tbl[vi].en);
        chk($sformatf("le_d_k%0d", k), d0, tbl[vi].d);
        chk($sformatf("le_busy_k%0d", k), busy0, tbl[vi].busy);
        chk($sformatf("le_empty_k%0d", k), empty0, tbl[vi].empty);
        vi++;
      end
    end
    chk("le_sb_drained", sb0.size(), 0);

    // Full boundary: ninth write dropped.
    for (int i = 1; i <= 8; i++) push0(16'(i), 1);
    chk("fb_full", full0, 1);
    chk("fb_count8", count0, 8);
    push0(16'h0009, 0);
    chk("fb_count_after_drop", count0, 8);
`ifdef MAV_SAMPLE_SRC_DROP_CNT_EN
    chk("fb_drop_cnt", drop0, 1);
`endif
    pulse_start0();
    wait_idle0("fb");
    chk("fb_sb_drained", sb0.size(), 0);
    chk("fb_empty", empty0, 1);

    // Push while full on the pop cycle: accepted, emitted last.
    for (int i = 0; i < 8; i++) push0(16'h0010 + 16'(i), 1);
    pulse_start0();
    repeat (3) tick();
    push0(16'h00AA, 1);
    chk("pf_en", en0, 1);
    chk("pf_count", count0, 8);
    chk("pf_full", full0, 1);
    wait_idle0("pf");
    chk("pf_sb_drained", sb0.size(), 0);

    // Reset between the 2nd and 3rd strobes.
    push0(16'h0021, 1); push0(16'h0022, 1); push0(16'h0023, 1); push0(16'h0024, 1);
    s_before = strobes0;
    pulse_start0();
    repeat (9) tick();
    chk("mr_two_strobes", strobes0 - s_before, 2);
    rstn = 1'b0;
    #1;
    sb0.delete();
    chk("mr_en", en0, 0);
    chk("mr_d", d0, 0);
    chk("mr_count", count0, 0);
    chk("mr_empty", empty0, 1);
    chk("mr_busy", busy0, 0);
    tick();
    rstn = 1'b1;
    s_before = strobes0;
    repeat (20) tick();
    chk("mr_no_strobes", strobes0 - s_before, 0);

    // GAP=1 refill: continuous strobes while pushes keep arriving.
    wr_en1 = 1'b1; wr_data1 = 16'h0050; tick(); wr_en1 = 1'b0;
    sb1.push_back(16'h0050);
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en1 = 1'b1;
      wr_data1 = 16'h0005 + 16'(i);
      tick();
      sb1.push_back(16'h0005 + 16'(i));
      chk($sformatf("rf_en%0d", i), en1, 1);
      chk($sformatf("rf_count%0d", i), count1, 1);
    end
    wr_en1 = 1'b0;
    tick();
    chk("rf_en_last", en1, 1);
    tick();
    chk("rf_en_off", en1, 0);
    chk("rf_busy_off", busy1, 0);
    chk("rf_sb_drained", sb1.size(), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
